// File: rtl/tt_um_mux_scan_pkg.sv
// Shared definitions for the NUM_CH:1 scanning bit selector tile.
// Holds the sequencer state encoding and the bit positions of the fields
// packed onto uo_out and decoded from uio_in.
package tt_um_mux_scan_pkg;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  // uo_out field positions
  localparam int OUT_BIT   = 0;
  localparam int SEL_LSB   = 1;
  localparam int SEL_FLD_W = 3;
  localparam int WRAP_BIT  = 4;
  localparam int MODE_BIT  = 5;

  // uio_in field positions
  localparam int MODE_IN   = 3;
  localparam int DWELL_LSB = 4;

endpackage

// File: rtl/mux_scan_seq.sv
// Select sequencer for the scanning bit selector.
// MANUAL: the select follows the pins. SCAN: the select steps through
// 0..NUM_CH-1, holding each channel for dwell_in+1 cycles, and wrap
// pulses for one cycle after a genuine NUM_CH-1 -> 0 step.
// Ports:
//   clk, rst (sync, active-high), ena (0 freezes every register)
//   mode     : 1 requests SCAN, 0 requests MANUAL
//   man_sel  : select from the pins
//   dwell_in : dwell reload value
//   sel      : registered select (may be out of range in MANUAL)
//   wrap     : one-cycle wrap pulse
//   mode_q   : 1 while in SCAN
module mux_scan_seq
  import tt_um_mux_scan_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               mode,
  input  logic [SEL_W-1:0]   man_sel,
  input  logic [DWELL_W-1:0] dwell_in,
  output logic [SEL_W-1:0]   sel,
  output logic               wrap,
  output logic               mode_q
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               wrap_q, wrap_d;

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    sel_d   = sel_q;
    wrap_d  = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        // The scan starts from whatever the pins select on entry.
        sel_d = man_sel;
        if (mode) begin
          state_d = ST_SCAN;
          dwell_d = dwell_in;
        end
      end
      ST_SCAN: begin
        // Mode drop outranks a dwell expiry in the same cycle.
        if (!mode) begin
          state_d = ST_MANUAL;
          sel_d   = man_sel;
          dwell_d = '0;
        end else if (dwell_q != '0) begin
          dwell_d = dwell_q - DWELL_W'(1);
        end else begin
          dwell_d = dwell_in;
          if (sel_q >= LAST_SEL) begin
            // Out-of-range selects recover to 0 without flagging a wrap.
            sel_d  = '0;
            wrap_d = (sel_q == LAST_SEL);
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
      default: state_d = ST_MANUAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_MANUAL;
      dwell_q <= '0;
      sel_q   <= '0;
      wrap_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      sel_q   <= sel_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sel    = sel_q;
  assign wrap   = wrap_q;
  assign mode_q = (state_q == ST_SCAN);

endmodule

// File: rtl/tt_um_mux_scan.sv
// TinyTapeout tile: NUM_CH:1 registered bit selector with manual and
// dwell-timed scan modes.
// Ports:
//   clk, rst (sync, active-high), ena (0 freezes every register)
//   ui_in   : [NUM_CH-1:0] data channels
//   uio_in  : [2:0] manual select, [3] mode (1=SCAN), [7:4] dwell load
//   uo_out  : [0] selected bit, [3:1] select, [4] wrap, [5] mode, [7:6] 0
//   uio_out : constant 0
//   uio_oe  : constant 0 (all uio pins are inputs)
module tt_um_mux_scan
  import tt_um_mux_scan_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  logic [SEL_W-1:0]     sel;
  logic                 wrap;
  logic                 mode_q;
  logic                 out_q, out_d;
  logic [SEL_FLD_W-1:0] sel_ext;
  logic                 unused_pins;

  mux_scan_seq #(
    .NUM_CH  (NUM_CH),
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .mode     (uio_in[MODE_IN]),
    .man_sel  (uio_in[SEL_W-1:0]),
    .dwell_in (uio_in[DWELL_LSB +: DWELL_W]),
    .sel      (sel),
    .wrap     (wrap),
    .mode_q   (mode_q)
  );

  // The mux reads the registered select, so a pin select reaches
  // uo_out[0] two cycles later while data reaches it in one.
  always_comb begin
    out_d = 1'b0;
    if (int'(sel) < NUM_CH) out_d = ui_in[sel];
  end

  always_ff @(posedge clk) begin
    if (rst)      out_q <= 1'b0;
    else if (ena) out_q <= out_d;
  end

  assign sel_ext = SEL_FLD_W'(sel);

  always_comb begin
    uo_out                          = 8'h00;
    uo_out[OUT_BIT]                 = out_q;
    uo_out[SEL_LSB +: SEL_FLD_W]    = sel_ext;
    uo_out[WRAP_BIT]                = wrap;
    uo_out[MODE_BIT]                = mode_q;
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Upper data channels and spare uio bits are deliberately ignored.
  assign unused_pins = ^{ui_in, uio_in};

endmodule

// File: tb/tb_tt_um_mux_scan.sv
module tb_tt_um_mux_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo8, uio_out8, uio_oe8;
  logic [7:0] uo3, uio_out3, uio_oe3;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, index 0 = 8-channel DUT, 1 = 3-channel DUT.
  int m_mode[2], m_sel[2], m_dw[2], m_out[2], m_wrap[2];
  int nch[2] = '{8, 3};

  always #5 clk = ~clk;

  tt_um_mux_scan #(.NUM_CH(8), .SEL_W(3), .DWELL_W(4)) dut8 (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uio_out(uio_out8), .uio_oe(uio_oe8), .uo_out(uo8)
  );

  tt_um_mux_scan #(.NUM_CH(3), .SEL_W(3), .DWELL_W(4)) dut3 (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uio_out(uio_out3), .uio_oe(uio_oe3), .uo_out(uo3)
  );

  function automatic logic [7:0] exp_uo(int k);
    logic [7:0] v;
    v      = 8'h00;
    v[0]   = m_out[k][0];
    v[3:1] = m_sel[k][2:0];
    v[4]   = m_wrap[k][0];
    v[5]   = m_mode[k][0];
    return v;
  endfunction

  // One clock edge: advance the model from the inputs present at the edge,
  // then settle 1 time unit so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_mode[k] = 0; m_sel[k] = 0; m_dw[k] = 0; m_out[k] = 0; m_wrap[k] = 0;
      end else if (ena) begin
        int ms;
        int dwin;
        int md;
        ms   = int'(uio_in[2:0]);
        dwin = int'(uio_in[7:4]);
        md   = int'(uio_in[3]);
        m_out[k]  = (m_sel[k] < nch[k]) ? int'(ui_in[m_sel[k]]) : 0;
        m_wrap[k] = 0;
        if (m_mode[k] == 0) begin
          m_sel[k] = ms;
          if (md == 1) begin m_mode[k] = 1; m_dw[k] = dwin; end
        end else if (md == 0) begin
          m_mode[k] = 0; m_sel[k] = ms; m_dw[k] = 0;
        end else if (m_dw[k] > 0) begin
          m_dw[k] = m_dw[k] - 1;
        end else begin
          m_dw[k] = dwin;
          if (m_sel[k] >= nch[k] - 1) begin
            m_wrap[k] = (m_sel[k] == nch[k] - 1) ? 1 : 0;
            m_sel[k]  = 0;
          end else begin
            m_sel[k] = m_sel[k] + 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1;
    tick(); tick();
    n_cmp++; if (uo8 !== 8'h00) begin n_bad++; $display("FAIL reset_uo8 got %h want 00", uo8); end
    n_cmp++; if (uo3 !== 8'h00) begin n_bad++; $display("FAIL reset_uo3 got %h want 00", uo3); end
    n_cmp++; if (uio_oe8 !== 8'h00) begin n_bad++; $display("FAIL reset_uio_oe got %h want 00", uio_oe8); end
    n_cmp++; if (uio_out8 !== 8'h00) begin n_bad++; $display("FAIL reset_uio_out got %h want 00", uio_out8); end
    rst = 1'b0;
  endtask

  task automatic test_manual();
    ui_in = 8'h04; uio_in = 8'h02;
    tick();
    n_cmp++; if (uo8[3:1] !== 3'd2) begin n_bad++; $display("FAIL manual_sel got %0d want 2", uo8[3:1]); end
    tick();
    n_cmp++; if (uo8[0] !== 1'b1) begin n_bad++; $display("FAIL manual_out got %b want 1", uo8[0]); end
    n_cmp++; if (uo8 !== exp_uo(0)) begin n_bad++; $display("FAIL manual_model got %h want %h", uo8, exp_uo(0)); end
    ui_in = 8'h00;
    tick();
    n_cmp++; if (uo8[0] !== 1'b0) begin n_bad++; $display("FAIL manual_data_lat got %b want 0", uo8[0]); end
  endtask

  task automatic test_scan_full();
    int wraps;
    ui_in = 8'h5A; uio_in = 8'h08;
    tick();
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (uo8[4] === 1'b1) wraps++;
      n_cmp++; if (uo8[3:1] !== 3'((i + 1) % 8)) begin n_bad++; $display("FAIL scan_seq cyc %0d got %0d want %0d", i, uo8[3:1], (i + 1) % 8); end
      n_cmp++; if (uo8 !== exp_uo(0)) begin n_bad++; $display("FAIL scan_model8 cyc %0d got %h want %h", i, uo8, exp_uo(0)); end
      n_cmp++; if (uo3 !== exp_uo(1)) begin n_bad++; $display("FAIL scan_model3 cyc %0d got %h want %h", i, uo3, exp_uo(1)); end
    end
    n_cmp++; if (wraps != 2) begin n_bad++; $display("FAIL scan_wraps got %0d want 2", wraps); end
    uio_in = 8'h05;
    tick();
    n_cmp++; if (uo8[3:1] !== 3'd5 || uo8[5] !== 1'b0) begin n_bad++; $display("FAIL scan_drop got %h want sel 5 mode 0", uo8); end
  endtask

  task automatic test_dwell();
    int wraps;
    ui_in = 8'hAA; uio_in = 8'h38;
    tick();
    wraps = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (uo8[4] === 1'b1) wraps++;
      n_cmp++; if (uo8[3:1] !== 3'(((i + 1) / 4) % 8)) begin n_bad++; $display("FAIL dwell_seq cyc %0d got %0d want %0d", i, uo8[3:1], ((i + 1) / 4) % 8); end
      n_cmp++; if (uo8 !== exp_uo(0)) begin n_bad++; $display("FAIL dwell_model8 cyc %0d got %h want %h", i, uo8, exp_uo(0)); end
      n_cmp++; if (uo3 !== exp_uo(1)) begin n_bad++; $display("FAIL dwell_model3 cyc %0d got %h want %h", i, uo3, exp_uo(1)); end
    end
    n_cmp++; if (wraps != 2) begin n_bad++; $display("FAIL dwell_wraps got %0d want 2", wraps); end
  endtask

  task automatic test_range();
    uio_in = 8'h05; ui_in = 8'hFF;
    tick(); tick();
    n_cmp++; if (uo3[3:1] !== 3'd5 || uo3[0] !== 1'b0) begin n_bad++; $display("FAIL range_manual got %h want sel 5 out 0", uo3); end
    uio_in = 8'h0D;
    tick();
    n_cmp++; if (uo3[3:1] !== 3'd5) begin n_bad++; $display("FAIL range_entry got %0d want 5", uo3[3:1]); end
    tick();
    n_cmp++; if (uo3[3:1] !== 3'd0 || uo3[4] !== 1'b0) begin n_bad++; $display("FAIL range_recover got %h want sel 0 wrap 0", uo3); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (uo3[3:1] !== 3'((i + 1) % 3) || uo3[4] !== ((i + 1) % 3 == 0)) begin
        n_bad++; $display("FAIL range_scan cyc %0d got %h want sel %0d", i, uo3, (i + 1) % 3);
      end
      n_cmp++; if (uo3 !== exp_uo(1)) begin n_bad++; $display("FAIL range_model cyc %0d got %h want %h", i, uo3, exp_uo(1)); end
    end
  endtask

  task automatic test_ena_hold();
    logic [7:0] snap8, snap3;
    uio_in = 8'h38; ui_in = 8'h96;
    for (int i = 0; i < 6; i++) tick();
    snap8 = exp_uo(0); snap3 = exp_uo(1);
    ena = 1'b0;
    ui_in = 8'h69;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (uo8 !== snap8) begin n_bad++; $display("FAIL hold8 cyc %0d got %h want %h", i, uo8, snap8); end
      n_cmp++; if (uo3 !== snap3) begin n_bad++; $display("FAIL hold3 cyc %0d got %h want %h", i, uo3, snap3); end
    end
    ena = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (uo8 !== exp_uo(0)) begin n_bad++; $display("FAIL resume8 cyc %0d got %h want %h", i, uo8, exp_uo(0)); end
      n_cmp++; if (uo3 !== exp_uo(1)) begin n_bad++; $display("FAIL resume3 cyc %0d got %h want %h", i, uo3, exp_uo(1)); end
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; ena = 1'b0;
    tick();
    n_cmp++; if (uo8 !== 8'h00) begin n_bad++; $display("FAIL rstprio_uo8 got %h want 00", uo8); end
    n_cmp++; if (uo3 !== 8'h00) begin n_bad++; $display("FAIL rstprio_uo3 got %h want 00", uo3); end
    rst = 1'b0; ena = 1'b1;
  endtask

  task automatic test_random();
    logic md;
    md = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) md = ~md;
      ui_in  = 8'($urandom);
      uio_in = {4'($urandom_range(0, 15)), md, 3'($urandom_range(0, 7))};
      ena    = ($urandom_range(0, 9) != 0);
      rst    = ($urandom_range(0, 99) == 0);
      tick();
      n_cmp++; if (uo8 !== exp_uo(0)) begin n_bad++; $display("FAIL rand8 cyc %0d got %h want %h", i, uo8, exp_uo(0)); end
      n_cmp++; if (uo3 !== exp_uo(1)) begin n_bad++; $display("FAIL rand3 cyc %0d got %h want %h", i, uo3, exp_uo(1)); end
      n_cmp++; if ({uio_oe8, uio_out8, uio_oe3, uio_out3} !== 32'h0) begin
        n_bad++; $display("FAIL rand_uio cyc %0d got %h want 0", i, {uio_oe8, uio_out8, uio_oe3, uio_out3});
      end
    end
    rst = 1'b0; ena = 1'b1;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_full();
    test_dwell();
    test_range();
    test_ena_hold();
    test_reset_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
